sram_arbiter: RTL
=================

# sram_arbiter

Sequencer and two-port arbiter for the board's external 1M x 16 asynchronous SRAM. It shares the SRAM between the host port and a read-only video port. The host port is driven from the CPU-side pointer/data PIO registers; the video port is driven by the framebuffer scan-out logic. The block generates all SRAM control strobes with programmable wait states and enforces bus turnaround. It arbitrates with fixed video priority plus a host anti-starvation limit.

## Interface
- RD_WAIT, 1: extra read cycles; a read access holds the SRAM for RD_WAIT+1 cycles.
- WR_WAIT, 1: extra write cycles; sram_we_n is low for WR_WAIT+1 cycles.
- STARVE_LIMIT, 4: maximum consecutive video grants while the host is pending (range 1-15).
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- host_addr  in  20  host word address.
- host_wdata  in  16  host write data.
- host_be  in  2  host byte enables; bit1 = upper byte, bit0 = lower byte.
- host_rd / host_wr  in  1  host read / write request, level, held until host_ack.
- host_ack  out  1  one-cycle pulse: request accepted and address/data latched.
- host_rvalid  out  1  one-cycle pulse: host_rdata valid.
- host_rdata  out  16  host read data, held until the next host read completes.
- vid_addr  in  20  video word address.
- vid_rd  in  1  video read request, level.
- vid_ack / vid_rvalid  out  1  same semantics as the host signals.
- vid_rdata  out  16  video read data.
- sram_addr  out  20; sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each.
- sram_dq_out  out  16; sram_dq_oe  out  1; sram_dq_in  in  16. The top level forms the tristate.

## Operation
- All outputs are registered.
- Reset values:
  - sram_ce_n, oe_n, we_n, ub_n, lb_n = 1.
  - sram_dq_oe = 0; sram_addr = 0; sram_dq_out = 0.
  - All ack/rvalid = 0; rdata = 0.
  - FSM = IDLE; starve counter = 0.
- FSM states: IDLE, READ, WRITE, WREC.
- IDLE: samples the requests and grants at most one. Grant order:
  - If host is pending and the starve counter equals STARVE_LIMIT, grant the host.
  - Else if vid_rd is high, grant video.
  - Else if host_wr or host_rd is high, grant the host.
- On a grant, at the same edge:
  - Latch the address, data and byte enables.
  - Pulse the matching ack in the following cycle.
  - Load the wait counter.
- READ:
  - Outputs: ce_n=0, oe_n=0, ub_n=lb_n=0, dq_oe=0.
  - Lasts RD_WAIT+1 cycles.
  - At the final edge, capture sram_dq_in into the granted port's rdata, pulse its rvalid the next cycle, and go to IDLE.
- WRITE:
  - Outputs: ce_n=0, oe_n=1, we_n=0, dq_oe=1, ub_n=~be[1], lb_n=~be[0].
  - Lasts WR_WAIT+1 cycles, then go to WREC.
- WREC:
  - Lasts 1 cycle; we_n=1, and dq_oe and the address stay stable (hold time).
  - Then go to IDLE with ce_n=1.
- host_wr and host_rd both high: the write is performed; the read is not serviced. This is a protocol error and no rvalid follows.
- host_be=00 write: the cycle runs with ub_n=lb_n=1, the SRAM is unchanged, and host_ack pulses normally.
- Starve counter:
  - Increments on each video grant made while the host is pending; saturates at STARVE_LIMIT.
  - Clears on a host grant, or in any IDLE cycle with the host not pending.
- Requesters drop the request or present the next one in the cycle after they see ack. The FSM is non-IDLE during the ack cycle, so a held request is never double-granted.
- A reset mid-access forces the reset values immediately and asynchronously. The in-flight access is dropped; no ack or rvalid is issued for it.

## Timing
- Grant edge E0: ack is high during cycle E0→E1.
- Read: rdata is captured at edge E(RD_WAIT+1); rvalid is high in the following cycle, i.e. RD_WAIT+1 cycles after ack. Port occupancy is RD_WAIT+2 cycles (3 at default).
- Write: we_n is low for WR_WAIT+1 cycles and dq_oe is high for WR_WAIT+2 cycles. Occupancy is WR_WAIT+3 cycles (4 at default).
- sram_dq_oe is never high while sram_oe_n is low, including across READ→IDLE→WRITE. There is at least one idle cycle between the end of a read and the start of a drive.

## Test plan
- Reset with vid_rd and host_wr high → all strobes 1 and dq_oe 0. After release, the first grant occurs on the first IDLE edge and goes to video.
- Host write addr 0x12345, data 0xBEEF, be=11 → one host_ack; we_n low exactly 2 cycles; dq_oe high 3 cycles; sram_addr=0x12345 throughout. A following host read returns 0xBEEF, with rvalid 2 cycles after ack.
- Host write be=01, data 0x55AA over 0xBEEF → lb_n=0, ub_n=1. A following read returns 0xBEAA in the memory model.
- vid_rd and host_rd asserted in the same cycle → vid_ack first, host_ack at the next IDLE. Each rdata matches its own address; no cross-delivery.
- vid_rd held continuously and host_rd held, STARVE_LIMIT=4 → exactly 4 vid_acks, then host_ack, then video resumes. The counter reads 0 after the host grant.
- reset_n pulsed low mid-WRITE → we_n, ce_n = 1 and dq_oe = 0 within the reset cycle. No ack or rvalid follows; normal operation resumes after release.

Source files
------------

// File: rtl/sram_arbiter.sv
// Sequencer and two-port arbiter for the external 1M x 16 asynchronous SRAM.
// Video reads have fixed priority; the host is promoted after STARVE_LIMIT video grants.
module sram_arbiter #(
  parameter int RD_WAIT      = 1,
  parameter int WR_WAIT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [19:0] host_addr,
  input  logic [15:0] host_wdata,
  input  logic [1:0]  host_be,
  input  logic        host_rd,
  input  logic        host_wr,
  output logic        host_ack,
  output logic        host_rvalid,
  output logic [15:0] host_rdata,
  input  logic [19:0] vid_addr,
  input  logic        vid_rd,
  output logic        vid_ack,
  output logic        vid_rvalid,
  output logic [15:0] vid_rdata,
  output logic [19:0] sram_addr,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic [1:0]  dbg_state,
  output logic [3:0]  dbg_starve_cnt
);

  // Handshake: a request is a level held until its ack pulse; the ack marks the
  // edge where address/data/byte enables were latched. rvalid is a one-cycle
  // pulse with rdata valid, and rdata holds until that port's next read completes.

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, WREC = 2'd3} state_t;

  localparam int            CW     = 8;
  localparam logic [CW-1:0] RD_CNT = CW'(RD_WAIT);
  localparam logic [CW-1:0] WR_CNT = CW'(WR_WAIT);
  localparam logic [3:0]    LIMIT  = 4'(STARVE_LIMIT);

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [3:0]    starve_q, starve_d;
  logic          owner_vid_q, owner_vid_d;
  logic [1:0]    be_q, be_d;
  logic [19:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          host_ack_q, host_ack_d, vid_ack_q, vid_ack_d;
  logic          host_rvalid_q, host_rvalid_d, vid_rvalid_q, vid_rvalid_d;
  logic [15:0]   host_rdata_q, host_rdata_d, vid_rdata_q, vid_rdata_d;
  logic          ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic          ub_n_q, ub_n_d, lb_n_q, lb_n_d, dq_oe_q, dq_oe_d;

  logic host_pend, grant_host, grant_vid;

  assign host_pend  = host_rd | host_wr;
  assign grant_host = (state_q == IDLE) && host_pend && ((starve_q == LIMIT) || !vid_rd);
  assign grant_vid  = (state_q == IDLE) && vid_rd && !grant_host;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      wait_q        <= '0;
      starve_q      <= '0;
      owner_vid_q   <= 1'b0;
      be_q          <= 2'b00;
      addr_q        <= '0;
      wdata_q       <= '0;
      host_ack_q    <= 1'b0;
      vid_ack_q     <= 1'b0;
      host_rvalid_q <= 1'b0;
      vid_rvalid_q  <= 1'b0;
      host_rdata_q  <= '0;
      vid_rdata_q   <= '0;
      ce_n_q        <= 1'b1;
      oe_n_q        <= 1'b1;
      we_n_q        <= 1'b1;
      ub_n_q        <= 1'b1;
      lb_n_q        <= 1'b1;
      dq_oe_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      starve_q      <= starve_d;
      owner_vid_q   <= owner_vid_d;
      be_q          <= be_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      host_ack_q    <= host_ack_d;
      vid_ack_q     <= vid_ack_d;
      host_rvalid_q <= host_rvalid_d;
      vid_rvalid_q  <= vid_rvalid_d;
      host_rdata_q  <= host_rdata_d;
      vid_rdata_q   <= vid_rdata_d;
      ce_n_q        <= ce_n_d;
      oe_n_q        <= oe_n_d;
      we_n_q        <= we_n_d;
      ub_n_q        <= ub_n_d;
      lb_n_q        <= lb_n_d;
      dq_oe_q       <= dq_oe_d;
    end
  end

  // Next state, grant/latch and completion handling.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    starve_d      = starve_q;
    owner_vid_d   = owner_vid_q;
    be_d          = be_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    host_ack_d    = 1'b0;
    vid_ack_d     = 1'b0;
    host_rvalid_d = 1'b0;
    vid_rvalid_d  = 1'b0;
    host_rdata_d  = host_rdata_q;
    vid_rdata_d   = vid_rdata_q;
    case (state_q)
      IDLE: begin
        if (!host_pend) starve_d = '0;
        if (grant_host) begin
          starve_d    = '0;
          owner_vid_d = 1'b0;
          addr_d      = host_addr;
          wdata_d     = host_wdata;
          be_d        = host_be;
          host_ack_d  = 1'b1;
          // A simultaneous read+write request is serviced as the write only.
          if (host_wr) begin
            state_d = WRITE;
            wait_d  = WR_CNT;
          end else begin
            state_d = READ;
            wait_d  = RD_CNT;
          end
        end else if (grant_vid) begin
          if (host_pend && (starve_q != LIMIT)) starve_d = starve_q + 4'd1;
          owner_vid_d = 1'b1;
          addr_d      = vid_addr;
          vid_ack_d   = 1'b1;
          state_d     = READ;
          wait_d      = RD_CNT;
        end
      end
      READ: begin
        if (wait_q == '0) begin
          state_d = IDLE;
          if (owner_vid_q) begin
            vid_rdata_d  = sram_dq_in;
            vid_rvalid_d = 1'b1;
          end else begin
            host_rdata_d  = sram_dq_in;
            host_rvalid_d = 1'b1;
          end
        end else begin
          wait_d = wait_q - CW'(1);
        end
      end
      WRITE: begin
        if (wait_q == '0) state_d = WREC;
        else              wait_d  = wait_q - CW'(1);
      end
      WREC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered, so they are decoded from the state being entered.
  always_comb begin
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    ub_n_d  = 1'b1;
    lb_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    case (state_d)
      READ: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        ub_n_d = 1'b0;
        lb_n_d = 1'b0;
      end
      WRITE: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        ub_n_d  = ~be_d[1];
        lb_n_d  = ~be_d[0];
      end
      WREC: begin
        // Data and address held one more cycle past the rising we_n.
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        ub_n_d  = ~be_d[1];
        lb_n_d  = ~be_d[0];
      end
      default: ;
    endcase
  end

  assign host_ack       = host_ack_q;
  assign host_rvalid    = host_rvalid_q;
  assign host_rdata     = host_rdata_q;
  assign vid_ack        = vid_ack_q;
  assign vid_rvalid     = vid_rvalid_q;
  assign vid_rdata      = vid_rdata_q;
  assign sram_addr      = addr_q;
  assign sram_dq_out    = wdata_q;
  assign sram_ce_n      = ce_n_q;
  assign sram_oe_n      = oe_n_q;
  assign sram_we_n      = we_n_q;
  assign sram_ub_n      = ub_n_q;
  assign sram_lb_n      = lb_n_q;
  assign sram_dq_oe     = dq_oe_q;
  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_q;

endmodule
